// File: rtl/radix4_issue_ctrl_if.sv
// Streaming bundle between the operand source, radix4_issue_ctrl, the Radix4
// multiplier and the product consumer.
// Signals: operand input (inValid/inReady/inA/inB), multiplier drive and
// return (multStart/multA/multB/multResult), product output
// (outValid/outReady/outProduct) and a busy status flag.
interface radix4_issue_ctrl_if;
    logic        inValid;
    logic        inReady;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        multStart;
    logic [31:0] multA;
    logic [31:0] multB;
    logic [63:0] multResult;
    logic        outValid;
    logic        outReady;
    logic [63:0] outProduct;
    logic        busy;

    // Environment side: operand source, multiplier and product consumer.
    modport master (
        output inValid, inA, inB, multResult, outReady,
        input  inReady, multStart, multA, multB, outValid, outProduct, busy
    );

    // Sequencer side.
    modport slave (
        input  inValid, inA, inB, multResult, outReady,
        output inReady, multStart, multA, multB, outValid, outProduct, busy
    );
endinterface

// File: rtl/radix4_issue_ctrl.sv
// Operand FIFO + start/wait/capture sequencer wrapping the Radix4 multiplier.
// Latency: 1+START_CYCLES+MULT_LATENCY+1 edges from accept to outValid.
// Backpressure: inReady low when FIFO full; held output stalls FSM in CAPTURE.
//
// Ports: clk, rst_n (async active-low), bus (slave modport) carrying the
// operand handshake, multiplier start/operands/result, the product
// handshake and busy.
module radix4_issue_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int START_CYCLES = 2,
    parameter int MULT_LATENCY = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    radix4_issue_ctrl_if.slave   bus
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CMAX = (START_CYCLES > MULT_LATENCY) ? START_CYCLES : MULT_LATENCY;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // Operand FIFO: {inA, inB} per entry.
    logic [63:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          start_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic          out_vld_q;
    logic [63:0]   prod_q;

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = bus.inValid && !fifo_full;
    // The FSM is the only reader; it takes the head the moment it goes idle.
    assign pop        = (state == IDLE) && !fifo_empty;
    assign head       = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.inA, bus.inB};
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            start_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            out_vld_q <= 1'b0;
            prod_q    <= '0;
        end else begin
            // Consumer takes the product; a capture below may refill it
            // in the same cycle, keeping outValid high.
            if (out_vld_q && bus.outReady) begin
                out_vld_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        a_q     <= head[63:32];
                        b_q     <= head[31:0];
                        cnt     <= CW'(START_CYCLES - 1);
                        start_q <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt == '0) begin
                        start_q <= 1'b0;
                        cnt     <= CW'(MULT_LATENCY - 1);
                        state   <= WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    // Stalling here is safe: the multiplier keeps its result
                    // as long as start is not raised again.
                    if (!out_vld_q || bus.outReady) begin
                        prod_q    <= bus.multResult;
                        out_vld_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.inReady    = !fifo_full;
    assign bus.multStart  = start_q;
    assign bus.multA      = a_q;
    assign bus.multB      = b_q;
    assign bus.outValid   = out_vld_q;
    assign bus.outProduct = prod_q;
    assign bus.busy       = (state != IDLE) || !fifo_empty || out_vld_q;

endmodule

// File: tb/tb_radix4_issue_ctrl.sv
// Directed bench for radix4_issue_ctrl with a behavioural Radix4 model.
// Latency: model result valid MULT_LATENCY edges after start falls.
// Backpressure: outReady driven directly by the directed sequence.
module tb_radix4_issue_ctrl;

    localparam int LAT = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;

    radix4_issue_ctrl_if bus ();

    radix4_issue_ctrl #(
        .FIFO_DEPTH  (4),
        .START_CYCLES(2),
        .MULT_LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Multiplier model: output is garbage while start is high and until the
    // full latency has elapsed, then holds the product.
    logic [63:0] mres = 64'd0;
    logic        mrun = 1'b0;
    int          mcnt = 0;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    always @(posedge clk) begin
        if (bus.multStart) begin
            mrun <= 1'b1;
            mcnt <= 0;
            mres <= 64'hA5A5_5A5A_DEAD_BEEF;
        end else if (mrun) begin
            if (mcnt + 1 == LAT) begin
                mres <= smul(bus.multA, bus.multB);
                mrun <= 1'b0;
            end
            mcnt <= mcnt + 1;
        end
    end

    assign bus.multResult = mres;

    always @(negedge clk) begin
        if (bus.multStart) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves inValid high so consecutive calls push on consecutive edges.
    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n;
        bus.inValid = 1'b1;
        bus.inA     = a;
        bus.inB     = b;
        n = 0;
        while (!bus.inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", {63'd0, bus.inReady}, 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.outValid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("idle", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        int n;
        int s0;
        wait_idle();
        s0 = start_cnt;
        push(a, b);
        bus.inValid = 1'b0;
        wait_out(n);
        chk({tag, "_lat"}, 64'(n), 64'd24);
        chk({tag, "_vld"}, {63'd0, bus.outValid}, 64'd1);
        chk({tag, "_prod"}, bus.outProduct, exp);
        chk({tag, "_start"}, 64'(start_cnt - s0), 64'd2);
    endtask

    logic [63:0] got_p [5];
    int          got_t [5];
    int          got;
    int          n;
    int          bad;

    initial begin
        bus.inValid  = 1'b0;
        bus.inA      = '0;
        bus.inB      = '0;
        bus.outReady = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", {63'd0, bus.multStart}, 64'd0);
        chk("rst_multA", {32'd0, bus.multA}, 64'd0);
        chk("rst_multB", {32'd0, bus.multB}, 64'd0);
        chk("rst_outvld", {63'd0, bus.outValid}, 64'd0);
        chk("rst_prod", bus.outProduct, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_inready", {63'd0, bus.inReady}, 64'd1);

        // Single ops and signed corners
        run_one("single", 32'd553524, 32'd840, 64'd464960160);
        run_one("big", 32'd1348760118, 32'd1348543286, 64'd1818861401553467748);
        run_one("negneg", -32'sd259, -32'sd259, 64'd67081);
        run_one("negone", -32'sd1199060305, 32'd1, -64'sd1199060305);
        run_one("zeroa", 32'd0, 32'd1348760118, 64'd0);
        run_one("zerob", 32'd5, 32'd0, 64'd0);

        // Back-to-back: five pushes on consecutive edges
        wait_idle();
        push(32'd553524, 32'd840);
        push(-32'sd259, -32'sd259);
        push(-32'sd1199060305, -32'sd2005095693);
        push(32'd1348760118, 32'd1348543286);
        push(32'd7, -32'sd3);
        bus.inValid = 1'b0;
        chk("b2b_full", {63'd0, bus.inReady}, 64'd0);
        got = 0;
        n   = 0;
        while (got < 5 && n < 300) begin
            if (bus.outValid) begin
                got_p[got] = bus.outProduct;
                got_t[got] = n;
                got++;
            end
            @(negedge clk);
            n++;
        end
        chk("b2b_count", 64'(got), 64'd5);
        chk("b2b_first_t", 64'(got_t[0]), 64'd20);
        chk("b2b_gap1", 64'(got_t[1] - got_t[0]), 64'd24);
        chk("b2b_gap4", 64'(got_t[4] - got_t[3]), 64'd24);
        chk("b2b_p0", got_p[0], 64'd464960160);
        chk("b2b_p1", got_p[1], 64'd67081);
        chk("b2b_p2", got_p[2], 64'd2404230653202766365);
        chk("b2b_p3", got_p[3], 64'd1818861401553467748);
        chk("b2b_p4", got_p[4], -64'sd21);

        // Backpressure: first product held, second stalls in CAPTURE
        wait_idle();
        bus.outReady = 1'b0;
        push(32'd3, 32'd4);
        push(-32'sd5, 32'd6);
        bus.inValid = 1'b0;
        wait_out(n);
        chk("bp_first", bus.outProduct, 64'd12);
        bad = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (bus.outProduct !== 64'd12 || bus.outValid !== 1'b1) bad++;
        end
        chk("bp_hold", 64'(bad), 64'd0);
        chk("bp_busy", {63'd0, bus.busy}, 64'd1);
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.outReady = 1'b0;
        chk("bp_vld_cont", {63'd0, bus.outValid}, 64'd1);
        chk("bp_second", bus.outProduct, -64'sd30);
        bus.outReady = 1'b1;
        @(negedge clk);
        chk("bp_drain", {63'd0, bus.outValid}, 64'd0);
        chk("bp_idle", {63'd0, bus.busy}, 64'd0);

        // Reset during LOAD: start must drop immediately
        push(32'd9, 32'd9);
        bus.inValid = 1'b0;
        @(negedge clk);
        chk("load_start", {63'd0, bus.multStart}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("load_rst_start", {63'd0, bus.multStart}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-WAIT with three pairs queued
        push(32'd11, 32'd2);
        push(32'd12, 32'd2);
        push(32'd13, 32'd2);
        push(32'd14, 32'd2);
        bus.inValid = 1'b0;
        repeat (8) @(negedge clk);
        chk("wait_busy", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("wrst_start", {63'd0, bus.multStart}, 64'd0);
        chk("wrst_outvld", {63'd0, bus.outValid}, 64'd0);
        chk("wrst_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("wrst_inready", {63'd0, bus.inReady}, 64'd1);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.outValid !== 1'b0) bad++;
        end
        chk("wrst_no_out", 64'(bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
